// File: rtl/comparer_sequencer_pkg.sv
// Shared types and sizing helpers for the chunked magnitude comparator.
package comparer_sequencer_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} cmpseq_state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_result_t;

  function automatic int unsigned nchunks(input int unsigned width, input int unsigned chunk);
    return (width / chunk < 1) ? 1 : width / chunk;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparer_sequencer_comparer.sv
// Combinational signed/unsigned magnitude compare of one chunk.
module comparer_sequencer_comparer
  import comparer_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             unsigned_i,
  output cmp_result_t      res_o
);

  always_comb begin
    res_o    = '0;
    res_o.eq = (a_i == b_i);
    if (unsigned_i) begin
      res_o.gt = (a_i > b_i);
    end else begin
      res_o.gt = ($signed(a_i) > $signed(b_i));
    end
    res_o.lt = ~res_o.eq & ~res_o.gt;
  end

endmodule

// File: rtl/comparer_sequencer.sv
// Multi-cycle magnitude comparator: walks one chunk per cycle from the MSB chunk,
// stopping at the first unequal chunk and pulsing o_Done with registered flags.
module comparer_sequencer
  import comparer_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_Flush,
  input  logic [WIDTH-1:0] i_InputA,
  input  logic [WIDTH-1:0] i_InputB,
  input  logic             i_Unsigned,
  output logic             o_Ready,
  output logic             o_Done,
  output logic             o_EQ,
  output logic             o_GT,
  output logic             o_LT
);

  localparam int unsigned NChunks = nchunks(WIDTH, CHUNK);
  localparam int unsigned IdxW    = idx_width(NChunks);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunks - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("comparer_sequencer: WIDTH must be a multiple of CHUNK");
  end

  cmpseq_state_t   state_q;
  logic [IdxW-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            uns_q;
  logic            ready_q, done_q;
  cmp_result_t     res_q;

  logic [WIDTH-1:0] a_shift, b_shift;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_unsigned;
  cmp_result_t      chunk_res;
  int unsigned      shamt;

  assign shamt   = 32'(idx_q) * CHUNK;
  assign a_shift = a_q >> shamt;
  assign b_shift = b_q >> shamt;
  assign a_chunk = a_shift[CHUNK-1:0];
  assign b_chunk = b_shift[CHUNK-1:0];
  // Only the top chunk carries the sign; lower chunks are plain magnitudes.
  assign chunk_unsigned = uns_q || (idx_q != LastIdx);

  comparer_sequencer_comparer #(
    .WIDTH(CHUNK)
  ) u_comparer (
    .a_i       (a_chunk),
    .b_i       (b_chunk),
    .unsigned_i(chunk_unsigned),
    .res_o     (chunk_res)
  );

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      uns_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_Flush) begin
        // Flush in IDLE wins over start but leaves the last result visible.
        if (state_q != StIdle) res_q <= '0;
        state_q <= StIdle;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_Start) begin
              a_q     <= i_InputA;
              b_q     <= i_InputB;
              uns_q   <= i_Unsigned;
              idx_q   <= LastIdx;
              res_q   <= '0;
              ready_q <= 1'b0;
              state_q <= StRun;
            end
          end
          StRun: begin
            if (!chunk_res.eq || idx_q == '0) begin
              res_q   <= chunk_res;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end
          StDone: begin
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
          default: begin
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign o_Ready = ready_q;
  assign o_Done  = done_q;
  assign o_EQ    = res_q.eq;
  assign o_GT    = res_q.gt;
  assign o_LT    = res_q.lt;

endmodule

// File: tb/tb_comparer_sequencer.sv
// Scoreboard bench for comparer_sequencer: driver queues expected results, monitor checks on o_Done.
module tb_comparer_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, flush, uns;
  logic [31:0] in_a, in_b;
  logic        ready, done, eq, gt, lt;

  comparer_sequencer #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .i_Clock   (clk),
    .i_Reset   (rst_n),
    .i_Start   (start),
    .i_Flush   (flush),
    .i_InputA  (in_a),
    .i_InputB  (in_b),
    .i_Unsigned(uns),
    .o_Ready   (ready),
    .o_Done    (done),
    .o_EQ      (eq),
    .o_GT      (gt),
    .o_LT      (lt)
  );

  typedef struct {
    logic [2:0]  flags;  // {eq, gt, lt}
    int unsigned cyc;
    int unsigned id;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("flags_op%0d", e.id), {29'd0, eq, gt, lt}, {29'd0, e.flags});
        chk($sformatf("latency_op%0d", e.id), cyc, e.cyc);
        chk($sformatf("ready_low_op%0d", e.id), 32'(ready), 32'd0);
      end
    end
  end

  int unsigned op_id;

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                        input logic [2:0] flags, input int unsigned k);
    exp_t e;
    @(negedge clk);
    chk($sformatf("ready_before_op%0d", op_id), 32'(ready), 32'd1);
    in_a  = a;
    in_b  = b;
    uns   = u;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.flags = flags;
    e.cyc   = cyc + k;
    e.id    = op_id;
    sb_q.push_back(e);
    // Operands are sampled only at accept; scramble them afterwards.
    in_a = $urandom;
    in_b = $urandom;
    uns  = ~u;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      chk($sformatf("timeout_op%0d", op_id), 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("flags_hold_op%0d", op_id), {29'd0, eq, gt, lt}, {29'd0, flags});
    op_id++;
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    op_id    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    uns      = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_flags", {29'd0, eq, gt, lt}, 32'd0);

    //           A             B             uns   {eq,gt,lt} k
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 3'b100, 4);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001, 1);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b010, 1);
    run_op(32'h1234_5600, 32'h1234_56FF, 1'b1, 3'b001, 4);
    run_op(32'h0000_0080, 32'h0000_007F, 1'b0, 3'b010, 4);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b001, 1);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b010, 1);
    run_op(32'h7F00_0000, 32'h8000_0000, 1'b0, 3'b010, 1);
    run_op(32'h12FF_0000, 32'h1201_0000, 1'b0, 3'b010, 2);

    // Flush in the second RUN cycle of an equal compare.
    @(negedge clk);
    in_a  = 32'hCAFE_0001;
    in_b  = 32'hCAFE_0001;
    uns   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", 32'(ready), 32'd1);
    chk("flush_flags", {29'd0, eq, gt, lt}, 32'd0);
    repeat (6) @(negedge clk);
    chk("flush_no_done_ready", 32'(ready), 32'd1);
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 3'b001, 4);

    // Async reset in the middle of RUN.
    @(negedge clk);
    in_a  = 32'h5555_5555;
    in_b  = 32'h5555_5555;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_ready", 32'(ready), 32'd1);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_flags", {29'd0, eq, gt, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start and flush together in IDLE: no accept.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("start_flush_idle_ready", 32'(ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("start_flush_idle_still_ready", 32'(ready), 32'd1);
    chk("start_flush_idle_flags", {29'd0, eq, gt, lt}, 32'd0);

    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3'b100, 4);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
